// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I(M) execute stage: datapath width,
// shift-amount width and the ALU operation codes.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // Codes 12-15 and 24-31 are unassigned and yield zero.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_ADD4   = 5'd11,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

endpackage

// File: rtl/branch_comparator.sv
// Combinational branch comparator on the two register operands; feeds the
// PC-select logic in the same cycle.
module branch_comparator #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            BrUn,
  output logic            BrEq,
  output logic            BrLT,
  output logic            BrGE
);

  assign BrEq = (A == B);
  assign BrLT = BrUn ? (A < B) : ($signed(A) < $signed(B));
  assign BrGE = ~BrLT;

endmodule

// File: rtl/riscv_alu.sv
// Registered RV32I ALU with integrated branch comparator. Define
// RISCV_ALU_M_EXT_EN to build the M-extension multiply/divide operations.
module riscv_alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      ALU_Ctrl,
  input  logic            Bsel,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] Imm,
  input  logic            BrUn,
  output logic [XLEN-1:0] ALU_Out,
  output logic            zero,
  output logic            BrEq,
  output logic            BrLT,
  output logic            BrGE
);
  import riscv_pkg::*;

  logic [XLEN-1:0]    op2;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    result_d;
  logic [XLEN-1:0]    alu_out_q;
  logic               zero_q;

  assign op2   = Bsel ? Imm : B;
  assign shamt = op2[SHAMT_W-1:0];

`ifdef RISCV_ALU_M_EXT_EN
  logic [XLEN-1:0]   m_result;
  logic [2*XLEN-1:0] prod;
  logic              div_by_zero;
  logic              div_ovf;

  assign div_by_zero = (op2 == '0);
  assign div_ovf     = (A == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  // All products are formed as 64-bit modular multiplies of the
  // appropriately extended operands; the low half is identical for every form.
  always_comb begin
    m_result = '0;
    prod     = '0;
    case (ALU_Ctrl[2:0])
      3'd0: begin
        prod     = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{op2[XLEN-1]}}, op2};
        m_result = prod[XLEN-1:0];
      end
      3'd1: begin
        prod     = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{op2[XLEN-1]}}, op2};
        m_result = prod[2*XLEN-1:XLEN];
      end
      3'd2: begin
        prod     = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{1'b0}}, op2};
        m_result = prod[2*XLEN-1:XLEN];
      end
      3'd3: begin
        prod     = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, op2};
        m_result = prod[2*XLEN-1:XLEN];
      end
      3'd4: begin
        if (div_by_zero)  m_result = '1;
        else if (div_ovf) m_result = A;
        else              m_result = $signed(A) / $signed(op2);
      end
      3'd5: m_result = div_by_zero ? '1 : (A / op2);
      3'd6: begin
        if (div_by_zero)  m_result = A;
        else if (div_ovf) m_result = '0;
        else              m_result = $signed(A) % $signed(op2);
      end
      default: m_result = div_by_zero ? A : (A % op2);
    endcase
  end
`endif

  always_comb begin
    result_d = '0;
    case (ALU_Ctrl)
      ALU_ADD:   result_d = A + op2;
      ALU_SUB:   result_d = A - op2;
      ALU_SLL:   result_d = A << shamt;
      ALU_SLT:   result_d = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(op2))};
      ALU_SLTU:  result_d = {{(XLEN-1){1'b0}}, (A < op2)};
      ALU_XOR:   result_d = A ^ op2;
      ALU_SRL:   result_d = A >> shamt;
      ALU_SRA:   result_d = $unsigned($signed(A) >>> shamt);
      ALU_OR:    result_d = A | op2;
      ALU_AND:   result_d = A & op2;
      ALU_PASSB: result_d = op2;
      ALU_ADD4:  result_d = A + XLEN'(4);
`ifdef RISCV_ALU_M_EXT_EN
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: result_d = m_result;
`endif
      default:   result_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_out_q <= result_d;
      zero_q    <= (result_d == '0);
    end
  end

  assign ALU_Out = alu_out_q;
  assign zero    = zero_q;

  branch_comparator #(.XLEN(XLEN)) u_brcmp (
    .A    (A),
    .B    (B),
    .BrUn (BrUn),
    .BrEq (BrEq),
    .BrLT (BrLT),
    .BrGE (BrGE)
  );

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed cases plus randomized operations
// against an arithmetic reference model (honours RISCV_ALU_M_EXT_EN).
module tb_riscv_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ALU_Ctrl = '0;
  logic        Bsel = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Imm = '0;
  logic        BrUn = 1'b0;
  logic [31:0] ALU_Out;
  logic        zero;
  logic        BrEq;
  logic        BrLT;
  logic        BrGE;

  int n_vec  = 0;
  int n_miss = 0;

  riscv_alu dut (
    .clock    (clock),
    .reset    (reset),
    .ALU_Ctrl (ALU_Ctrl),
    .Bsel     (Bsel),
    .A        (A),
    .B        (B),
    .Imm      (Imm),
    .BrUn     (BrUn),
    .ALU_Out  (ALU_Out),
    .zero     (zero),
    .BrEq     (BrEq),
    .BrLT     (BrLT),
    .BrGE     (BrGE)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: operations evaluated as 64-bit integer arithmetic on the
  // signed/unsigned values of the operands, then reduced modulo 2^32.
  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] o2);
    longint          sa, so2;
    longint unsigned ua, uo2;
    int              sh;
    logic [31:0]     r;
    sa  = longint'($signed(a));
    so2 = longint'($signed(o2));
    ua  = {32'b0, a};
    uo2 = {32'b0, o2};
    sh  = int'(uo2 % 32);
    r   = 32'd0;
    case (c)
      5'd0:  r = 32'(ua + uo2);
      5'd1:  r = 32'(ua - uo2);
      5'd2:  r = 32'(ua * (64'd1 << sh));
      5'd3:  r = (sa < so2) ? 32'd1 : 32'd0;
      5'd4:  r = (ua < uo2) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ o2;
      5'd6:  r = 32'(ua / (64'd1 << sh));
      5'd7:  r = 32'(sa >>> sh);
      5'd8:  r = a | o2;
      5'd9:  r = a & o2;
      5'd10: r = o2;
      5'd11: r = 32'(ua + 4);
`ifdef RISCV_ALU_M_EXT_EN
      5'd16: r = 32'(sa * so2);
      5'd17: r = 32'((sa * so2) >>> 32);
      5'd18: r = 32'((sa * longint'(uo2)) >>> 32);
      5'd19: r = 32'((ua * uo2) >> 32);
      5'd20: r = (uo2 == 0) ? 32'hFFFF_FFFF : 32'(sa / so2);
      5'd21: r = (uo2 == 0) ? 32'hFFFF_FFFF : 32'(ua / uo2);
      5'd22: r = (uo2 == 0) ? a : 32'(sa % so2);
      5'd23: r = (uo2 == 0) ? a : 32'(ua % uo2);
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drive one operation half a cycle before the capturing edge, check the
  // combinational branch flags, then the registered result after the edge.
  task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic bsel, input logic brun);
    logic [31:0] exp;
    longint      sa, sb;
    logic        lt;
    ALU_Ctrl = c; A = a; B = b; Imm = imm; Bsel = bsel; BrUn = brun;
    exp = ref_alu(c, a, bsel ? imm : b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lt  = brun ? ({32'b0, a} < {32'b0, b}) : (sa < sb);
    #1;
    check("BrEq", {31'b0, BrEq}, {31'b0, (a == b)});
    check("BrLT", {31'b0, BrLT}, {31'b0, lt});
    check("BrGE", {31'b0, BrGE}, {31'b0, ~lt});
    @(posedge clock);
    #1;
    check("ALU_Out", ALU_Out, exp);
    check("zero", {31'b0, zero}, {31'b0, (exp == 32'd0)});
    $display("txn ctrl=%0d a=%h b=%h imm=%h bsel=%0d brun=%0d out=%h exp=%h",
             c, a, b, imm, bsel, brun, ALU_Out, exp);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return specials[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_out", ALU_Out, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    reset = 1'b0;

    // Asynchronous reset mid-run.
    do_op(5'd0, 32'h0000_1000, 32'h0000_0234, 32'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", ALU_Out, 32'd0);
    check("arst_zero", {31'b0, zero}, 32'd1);
    @(posedge clock);
    #1;
    check("arst_hold", ALU_Out, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);

    // Directed cases.
    do_op(5'd1,  32'd3,          32'd99,       32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(5'd0,  32'hFFFF_FFFF,  32'd1,        32'd0,         1'b0, 1'b0);
    do_op(5'd7,  32'h8000_0000,  32'd4,        32'd0,         1'b0, 1'b0);
    do_op(5'd6,  32'h8000_0000,  32'd4,        32'd0,         1'b0, 1'b0);
    do_op(5'd2,  32'd1,          32'h21,       32'd0,         1'b0, 1'b0);
    do_op(5'd3,  32'hFFFF_FFFF,  32'd1,        32'd0,         1'b0, 1'b0);
    do_op(5'd4,  32'hFFFF_FFFF,  32'd1,        32'd0,         1'b0, 1'b1);
    do_op(5'd0,  32'd9,          32'd9,        32'd0,         1'b0, 1'b1);
    do_op(5'd10, 32'd1,          32'd2,        32'hABCD_E000, 1'b1, 1'b0);
    do_op(5'd11, 32'h0000_0100,  32'd0,        32'd0,         1'b0, 1'b0);
    do_op(5'd13, 32'h1234_5678,  32'h1,        32'd0,         1'b0, 1'b0);
    do_op(5'd20, 32'd7,          32'd0,        32'd0,         1'b0, 1'b0);
    do_op(5'd22, 32'd7,          32'd0,        32'd0,         1'b0, 1'b0);
    do_op(5'd20, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0);
    do_op(5'd22, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0);
    do_op(5'd19, 32'hFFFF_FFFF,  32'd2,        32'd0,         1'b0, 1'b1);
    do_op(5'd16, 32'd3,          32'd4,        32'd0,         1'b0, 1'b0);

    // Randomized operations across the whole code space.
    for (int i = 0; i < 300; i++) begin
      do_op(5'($urandom_range(0, 31)), rnd_word(), rnd_word(), rnd_word(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
